// File: rtl/onchip_mem_arbiter_if.sv
// One Avalon-MM master port as seen by the on-chip memory arbiter.
// The master modport is the Nios interconnect side and the slave modport is the arbiter side.
interface onchip_mem_arbiter_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   parameter int BE_W   = DATA_W/8
);
   logic              read;
   logic              write;
   logic [ADDR_W-1:0] address;
   logic [BE_W-1:0]   byteenable;
   logic [DATA_W-1:0] writedata;
   logic              lock;
   logic              waitrequest;
   logic [DATA_W-1:0] readdata;
   logic              readdatavalid;

   modport master (
      output read, write, address, byteenable, writedata, lock,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  read, write, address, byteenable, writedata, lock,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip RAM with a 1-cycle read latency.
// Grant is combinational, so one transfer can be accepted every cycle. A read accepted in one cycle
// returns a readdatavalid pulse to its owner in the next cycle.
// Optional feature: define MEM_ARB_LOCK_EN to honour mN_lock. A locking master keeps the memory for
// up to LOCK_MAX consecutive grants. Without the macro, mN_lock is ignored.
module onchip_mem_arbiter #(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 32,
   parameter int BE_W     = DATA_W/8,
   parameter int LOCK_MAX = 16,
   parameter int CNT_W    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   onchip_mem_arbiter_if.slave  m0,
   onchip_mem_arbiter_if.slave  m1,
   output logic                 mem_chipselect,
   output logic                 mem_write,
   output logic [ADDR_W-1:0]    mem_address,
   output logic [BE_W-1:0]      mem_byteenable,
   output logic [DATA_W-1:0]    mem_writedata,
   input  logic [DATA_W-1:0]    mem_readdata,
   output logic [CNT_W-1:0]     gnt_cnt0,
   output logic [CNT_W-1:0]     gnt_cnt1
);

   logic [1:0]            req;
   logic [1:0]            wr;
   logic [1:0]            gnt;
   logic                  accept;
   logic                  win_id;
   logic                  last_grant;
   logic                  rd_owner_vld;
   logic                  rd_owner_id;
   logic [1:0][CNT_W-1:0] gcnt;

   // A master that asserts read and write together is treated as writing.
   assign req    = {m1.read | m1.write, m0.read | m0.write};
   assign wr     = {m1.write, m0.write};
   assign accept = |gnt;
   assign win_id = gnt[1];

`ifdef MEM_ARB_LOCK_EN
   localparam int LCNT_W = $clog2(LOCK_MAX + 1);
   localparam logic [LCNT_W-1:0] LOCK_LIM = LCNT_W'(LOCK_MAX);

   typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

   lock_state_t       state_q, state_d;
   logic              owner_q, owner_d;
   logic [LCNT_W-1:0] lock_cnt_q, lock_cnt_d;
   logic [LCNT_W-1:0] lock_cnt_nxt;
   logic [1:0]        lk;

   assign lk = {m1.lock, m0.lock};

   // Lock state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= UNLOCKED;
         owner_q    <= 1'b0;
         lock_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   // Lock next state. lock_cnt holds the number of consecutive locked grants already made, and the
   // grant that takes the lock is the first of them. When the count reaches LOCK_MAX, the lock is
   // released. last_grant has already moved to the owner at that point, so the other master wins
   // the next contention.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      lock_cnt_d   = lock_cnt_q;
      lock_cnt_nxt = ((state_q == LOCKED) ? lock_cnt_q : '0) + LCNT_W'(1);
      if (accept) begin
         if (lk[win_id] && (lock_cnt_nxt < LOCK_LIM)) begin
            state_d    = LOCKED;
            owner_d    = win_id;
            lock_cnt_d = lock_cnt_nxt;
         end else begin
            state_d    = UNLOCKED;
            lock_cnt_d = '0;
         end
      end
   end
`else
   logic unused_lock;
   assign unused_lock = m0.lock ^ m1.lock;
`endif

   // Round-robin grant. On contention, the master that did not win last time gets the grant.
   always_comb begin
      gnt = '0;
      if (req[0] && (!req[1] || last_grant)) gnt[0] = 1'b1;
      else if (req[1])                       gnt[1] = 1'b1;
`ifdef MEM_ARB_LOCK_EN
      // While locked, only the owner may win. The other master waits even if the owner is idle.
      if (state_q == LOCKED) begin
         gnt          = '0;
         gnt[owner_q] = req[owner_q];
      end
`endif
   end

   // Remember the last winner. This register holds its value through idle cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       last_grant <= 1'b1;
      else if (accept) last_grant <= win_id;
   end

   // Read return tracking. A reset drops any pending readdatavalid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_owner_vld <= 1'b0;
         rd_owner_id  <= 1'b0;
      end else begin
         rd_owner_vld <= accept && !wr[win_id];
         rd_owner_id  <= win_id;
      end
   end

   // Per-master counters of accepted transfers. Each counter saturates at all-ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gcnt <= '0;
      end else begin
         for (int i = 0; i < 2; i++)
            if (gnt[i] && (gcnt[i] != '1)) gcnt[i] <= gcnt[i] + CNT_W'(1);
      end
   end

   // The memory side follows the winner. With no grant, it shows master 0's bus with the strobes low.
   assign mem_chipselect = accept;
   assign mem_write      = accept & wr[win_id];
   assign mem_address    = gnt[1] ? m1.address    : m0.address;
   assign mem_byteenable = gnt[1] ? m1.byteenable : m0.byteenable;
   assign mem_writedata  = gnt[1] ? m1.writedata  : m0.writedata;

   assign m0.waitrequest   = req[0] & ~gnt[0];
   assign m1.waitrequest   = req[1] & ~gnt[1];
   assign m0.readdata      = mem_readdata;
   assign m1.readdata      = mem_readdata;
   assign m0.readdatavalid = rd_owner_vld & ~rd_owner_id;
   assign m1.readdatavalid = rd_owner_vld &  rd_owner_id;

   assign gnt_cnt0 = gcnt[0];
   assign gnt_cnt1 = gcnt[1];

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter, built with LOCK_MAX=4 and CNT_W=4. Lock expectations
// follow MEM_ARB_LOCK_EN.
module tb_onchip_mem_arbiter;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              mem_chipselect, mem_write;
   logic [ADDR_W-1:0] mem_address;
   logic [BE_W-1:0]   mem_byteenable;
   logic [DATA_W-1:0] mem_writedata;
   logic [DATA_W-1:0] mem_readdata;
   logic [CNT_W-1:0]  gnt_cnt0, gnt_cnt1;
   int                checks = 0;
   int                errors = 0;

   onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) m0_if ();
   onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) m1_if ();

   onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .LOCK_MAX(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .m0(m0_if.slave), .m1(m1_if.slave),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_address(mem_address),
      .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
      .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
   );

   always #5 clk = ~clk;

   // RAM model: 4096x32 with byte-enabled writes and a registered read.
   logic [DATA_W-1:0] ram [0:4095];
   always @(posedge clk) begin
      if (mem_chipselect) begin
         if (mem_write) begin
            for (int b = 0; b < BE_W; b++)
               if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
         end else begin
            mem_readdata <= ram[mem_address];
         end
      end
   end

   typedef struct {
      logic r0, w0; logic [11:0] a0; logic [3:0] be0; logic [31:0] d0;
      logic r1, w1; logic [11:0] a1; logic [3:0] be1; logic [31:0] d1;
      logic ew0, ew1, ev0, ev1, ecs, ewr;
      logic [11:0] eaddr; logic [3:0] ebe; logic [31:0] ewd; logic [31:0] erd;
   } vec_t;

   vec_t vt [14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic drv0(input logic r, input logic w, input logic [11:0] a, input logic [3:0] be,
                       input logic [31:0] d, input logic l);
      m0_if.read = r; m0_if.write = w; m0_if.address = a;
      m0_if.byteenable = be; m0_if.writedata = d; m0_if.lock = l;
   endtask

   task automatic drv1(input logic r, input logic w, input logic [11:0] a, input logic [3:0] be,
                       input logic [31:0] d, input logic l);
      m1_if.read = r; m1_if.write = w; m1_if.address = a;
      m1_if.byteenable = be; m1_if.writedata = d; m1_if.lock = l;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      logic exp_w0, exp_v0, exp_v1;
      int   win [8];

      // Positional fields: m0 r,w,addr,be,data | m1 r,w,addr,be,data |
      // exp wait0,wait1,rdv0,rdv1,cs,wr,addr,be,wdata,rdata
      vt[0]  = '{1,1'b0,12'h010,4'hF,32'h0,        0,0,12'h000,4'h0,32'h0,        0,0,0,0,1,0,12'h010,4'hF,32'h0,        32'h0};
      vt[0].w0 = 1; vt[0].r0 = 0; vt[0].d0 = 32'hDEADBEEF; vt[0].ewr = 1; vt[0].ewd = 32'hDEADBEEF;
      vt[1]  = '{1,0,12'h010,4'h0,32'h0,           0,0,12'h000,4'h0,32'h0,        0,0,0,0,1,0,12'h010,4'h0,32'h0,        32'h0};
      vt[2]  = '{0,0,12'h077,4'h0,32'h0,           0,0,12'h0AA,4'h0,32'h0,        0,0,1,0,0,0,12'h077,4'h0,32'h0,        32'hDEADBEEF};
      vt[3]  = '{0,0,12'h000,4'h0,32'h0,           0,1,12'hFFF,4'hF,32'hFFFFFFFF, 0,0,0,0,1,1,12'hFFF,4'hF,32'hFFFFFFFF, 32'h0};
      vt[4]  = '{0,0,12'h000,4'h0,32'h0,           0,1,12'hFFF,4'h3,32'h12345678, 0,0,0,0,1,1,12'hFFF,4'h3,32'h12345678, 32'h0};
      vt[5]  = '{0,0,12'h000,4'h0,32'h0,           1,0,12'hFFF,4'h0,32'h0,        0,0,0,0,1,0,12'hFFF,4'h0,32'h0,        32'h0};
      vt[6]  = '{0,0,12'h000,4'h0,32'h0,           0,0,12'h000,4'h0,32'h0,        0,0,0,1,0,0,12'h000,4'h0,32'h0,        32'hFFFF5678};
      vt[7]  = '{1,0,12'h010,4'h0,32'h0,           1,0,12'hFFF,4'h0,32'h0,        0,1,0,0,1,0,12'h010,4'h0,32'h0,        32'h0};
      vt[8]  = '{1,0,12'h010,4'h0,32'h0,           1,0,12'hFFF,4'h0,32'h0,        1,0,1,0,1,0,12'hFFF,4'h0,32'h0,        32'hDEADBEEF};
      vt[9]  = '{1,0,12'h010,4'h0,32'h0,           1,0,12'hFFF,4'h0,32'h0,        0,1,0,1,1,0,12'h010,4'h0,32'h0,        32'hFFFF5678};
      vt[10] = '{1,1,12'h020,4'hF,32'hCAFEF00D,    0,0,12'h000,4'h0,32'h0,        0,0,1,0,1,1,12'h020,4'hF,32'hCAFEF00D, 32'hDEADBEEF};
      vt[11] = '{1,0,12'h020,4'h0,32'h0,           0,1,12'h030,4'hF,32'h11111111, 1,0,0,0,1,1,12'h030,4'hF,32'h11111111, 32'h0};
      vt[12] = '{1,0,12'h020,4'h0,32'h0,           0,0,12'h000,4'h0,32'h0,        0,0,0,0,1,0,12'h020,4'h0,32'h0,        32'h0};
      vt[13] = '{0,0,12'h055,4'h0,32'h0,           0,0,12'h000,4'h0,32'h0,        0,0,1,0,0,0,12'h055,4'h0,32'h0,        32'hCAFEF00D};

      drv0(0, 0, 12'h0, 4'h0, 32'h0, 0);
      drv1(0, 0, 12'h0, 4'h0, 32'h0, 0);
      do_reset();
      #2;
      chk("rst_cs",   mem_chipselect,       0);
      chk("rst_wr",   mem_write,            0);
      chk("rst_rdv0", m0_if.readdatavalid,  0);
      chk("rst_rdv1", m1_if.readdatavalid,  0);
      chk("rst_cnt0", gnt_cnt0,             0);
      chk("rst_cnt1", gnt_cnt1,             0);
      tick();

      // Table: single-master traffic, byte-enable readback, contention, and the read+write case.
      for (int i = 0; i < 14; i++) begin
         drv0(vt[i].r0, vt[i].w0, vt[i].a0, vt[i].be0, vt[i].d0, 1'b0);
         drv1(vt[i].r1, vt[i].w1, vt[i].a1, vt[i].be1, vt[i].d1, 1'b0);
         #2;
         chk($sformatf("row%0d_wait0", i), m0_if.waitrequest,   vt[i].ew0);
         chk($sformatf("row%0d_wait1", i), m1_if.waitrequest,   vt[i].ew1);
         chk($sformatf("row%0d_rdv0", i),  m0_if.readdatavalid, vt[i].ev0);
         chk($sformatf("row%0d_rdv1", i),  m1_if.readdatavalid, vt[i].ev1);
         chk($sformatf("row%0d_cs", i),    mem_chipselect,      vt[i].ecs);
         chk($sformatf("row%0d_wr", i),    mem_write,           vt[i].ewr);
         chk($sformatf("row%0d_addr", i),  mem_address,         vt[i].eaddr);
         if (vt[i].ewr) begin
            chk($sformatf("row%0d_be", i), mem_byteenable, vt[i].ebe);
            chk($sformatf("row%0d_wd", i), mem_writedata,  vt[i].ewd);
         end
         if (vt[i].ev0 | vt[i].ev1) begin
            chk($sformatf("row%0d_rd0", i), m0_if.readdata, vt[i].erd);
            chk($sformatf("row%0d_rd1", i), m1_if.readdata, vt[i].erd);
         end
         tick();
      end
      #2;
      chk("tbl_cnt0", gnt_cnt0, 6);
      chk("tbl_cnt1", gnt_cnt1, 5);

      // Reset asserted in the cycle after a read accept drops the pending readdatavalid.
      do_reset();
      drv0(1, 0, 12'h010, 4'h0, 32'h0, 0);
      #2;
      chk("rstrd_wait0", m0_if.waitrequest, 0);
      chk("rstrd_cs",    mem_chipselect,    1);
      tick();
      reset = 1'b1;
      drv0(0, 0, 12'h0, 4'h0, 32'h0, 0);
      #2;
      chk("rstrd_rdv0_in", m0_if.readdatavalid, 0);
      tick();
      reset = 1'b0;
      #2;
      chk("rstrd_rdv0_out", m0_if.readdatavalid, 0);
      chk("rstrd_rdv1_out", m1_if.readdatavalid, 0);
      tick();

      // Continuous contention from reset: grants strictly alternate, starting with master 0.
      drv0(1, 0, 12'h010, 4'h0, 32'h0, 0);
      drv1(1, 0, 12'hFFF, 4'h0, 32'h0, 0);
      for (int c = 0; c < 8; c++) begin
         #2;
         exp_w0 = (c % 2) == 1;
         exp_v0 = (c > 0) && ((c - 1) % 2 == 0);
         exp_v1 = (c > 0) && ((c - 1) % 2 == 1);
         chk($sformatf("rr%0d_wait0", c), m0_if.waitrequest,   exp_w0);
         chk($sformatf("rr%0d_wait1", c), m1_if.waitrequest,   !exp_w0);
         chk($sformatf("rr%0d_rdv0", c),  m0_if.readdatavalid, exp_v0);
         chk($sformatf("rr%0d_rdv1", c),  m1_if.readdatavalid, exp_v1);
         if (exp_v0) chk($sformatf("rr%0d_rd0", c), m0_if.readdata, 32'hDEADBEEF);
         if (exp_v1) chk($sformatf("rr%0d_rd1", c), m1_if.readdata, 32'hFFFF5678);
         tick();
      end
      #2;
      chk("rr_cnt0", gnt_cnt0, 4);
      chk("rr_cnt1", gnt_cnt1, 4);

      // Master 1 requests the lock while both masters request continuously.
      drv0(0, 0, 12'h0, 4'h0, 32'h0, 0);
      drv1(0, 0, 12'h0, 4'h0, 32'h0, 0);
      do_reset();
`ifdef MEM_ARB_LOCK_EN
      win = '{0, 1, 1, 1, 1, 0, 1, 1};
`else
      win = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
      drv0(1, 0, 12'h010, 4'h0, 32'h0, 0);
      drv1(1, 0, 12'hFFF, 4'h0, 32'h0, 1);
      for (int c = 0; c < 8; c++) begin
         #2;
         chk($sformatf("lk%0d_wait0", c), m0_if.waitrequest, win[c] == 1);
         chk($sformatf("lk%0d_wait1", c), m1_if.waitrequest, win[c] == 0);
         tick();
      end

      // Grant counters saturate.
      drv1(0, 0, 12'h0, 4'h0, 32'h0, 0);
      drv0(0, 0, 12'h0, 4'h0, 32'h0, 0);
      do_reset();
      for (int c = 0; c < 20; c++) begin
         drv0(0, 1, 12'h100 + 12'(c), 4'hF, 32'(c), 0);
         tick();
         if (c == 14) begin
            #2;
            chk("sat_cnt0_15", gnt_cnt0, 4'hF);
         end
      end
      drv0(0, 0, 12'h0, 4'h0, 32'h0, 0);
      #2;
      chk("sat_cnt0_20", gnt_cnt0, 4'hF);
      chk("sat_cnt1",    gnt_cnt1, 4'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
